tdc_channel: RTL and testbench
==============================

# tdc_channel

Single-channel time-to-digital converter that timestamps the rising edge of a discriminator output and measures its time-over-threshold (ToT). It holds one completed event until the downstream output controller reads it. One instance per input channel sits directly upstream of the TDC output control stage, which concatenates `chan`, `time_over_threshold` and `timestamp` into the 68-bit FIFO word.

## Interface
- `CHANNEL_ID`, default 0: constant driven on `chan`.
- `CHAN_WIDTH`, default 4: width of `chan`.
- `TOT_WIDTH`, default 16: width of the ToT field.
- `TS_WIDTH`, default 48: width of the timestamp. `CHAN_WIDTH + TOT_WIDTH + TS_WIDTH` = 68.
- `MIN_TOT`, default 3: minimum accepted ToT in cycles. Used only with `TDC_GLITCH_FILTER_EN`.

Ports:
- `clk`  in  1  the single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `sig_in`  in  1  asynchronous discriminator output.
- `enable`  in  1  arms new captures when high.
- `clear`  in  1  single-cycle acknowledge from the consumer.
- `has_event`  out  1  a completed event is held.
- `chan`  out  CHAN_WIDTH  equals `CHANNEL_ID`.
- `time_over_threshold`  out  TOT_WIDTH  pulse width in clk cycles.
- `timestamp`  out  TS_WIDTH  counter value at the detected rising edge.
- `lost_events`  out  16  saturating count of dropped rising edges.

## Operation
- `sig_in` passes through a 2-flop synchronizer, then a registered edge detector that produces `rise` and `fall` pulses.
- A free-running `ts_cnt` (TS_WIDTH) increments every cycle and wraps modulo 2^TS_WIDTH. No wrap flag is produced.
- FSM states:
  - **IDLE**: if `rise && enable`, latch `ts_cnt` into the timestamp, set ToT to 1, and go to HIGH.
  - **HIGH**: ToT increments every cycle.
    - On `fall`: go to READY.
    - When ToT reaches 2^TOT_WIDTH−1 with no fall: saturate ToT, go to READY, and mark the channel as stuck.
  - **READY**: `has_event`=1; the timestamp and ToT outputs are frozen.
    - On `clear`: go to IDLE if the channel is stuck or `sig_in` is low; otherwise go to WAIT_LOW.
    - A `rise` seen in READY without a same-cycle `clear` is dropped, and `lost_events` increments, saturating at 0xFFFF.
  - **WAIT_LOW**: go to IDLE on `fall`. Any rise seen here is not captured and is not counted.
- `clear` and `rise` in the same READY cycle: the new edge is captured (timestamp latched, go to HIGH) and is not counted as lost.
- `clear` outside READY is ignored. `clear` held high during reset is harmless.
- `enable` deasserted in HIGH: the capture in progress completes normally. `enable` low in IDLE: rises are ignored and not counted.
- `chan` is a constant; it is not reset.

## Timing
- Reset values:
  - `has_event`=0, `time_over_threshold`=0, `timestamp`=0, `lost_events`=0.
  - FSM in IDLE, synchronizer flops cleared, `ts_cnt`=0.
- Reset mid-operation discards any in-progress or held event within one cycle.
- Latency from a raw `sig_in` rising edge to the `rise` pulse is 3 cycles. The timestamp equals `ts_cnt` in the `rise` cycle.
- ToT equals the number of cycles from the `rise` cycle up to, but not including, the `fall` cycle. This equals the synchronized high width.
- `has_event` asserts the cycle after the `fall` cycle (or the saturation cycle). It deasserts the cycle after `clear`.
- Event outputs are registered and stable for as long as `has_event`=1.
- Maximum event rate is one event per (ToT + 2) cycles when `clear` returns immediately.

## Configuration
- `TDC_GLITCH_FILTER_EN` defined:
  - On `fall` in HIGH with ToT < `MIN_TOT`, return to IDLE with no event and do not count it.
  - Saturation and all other behaviour are unchanged.
- `TDC_GLITCH_FILTER_EN` undefined: every completed pulse, including ToT=1, produces an event. `MIN_TOT` is unused.

## Test plan
- Reset, then a 10-cycle `sig_in` pulse with `ts_cnt` at 100 when `rise` fires → `has_event`=1, timestamp=100, ToT=10, `chan`=`CHANNEL_ID`; `clear` → `has_event`=0 the next cycle.
- Two pulses with no `clear` between them → first event held unchanged, `lost_events`=1; then `clear` and a `rise` in the same cycle → second capture taken, `lost_events` stays 1.
- `sig_in` held high with TOT_WIDTH=4 → event with ToT=15; `clear` while still high → WAIT_LOW; a new capture happens only after fall then rise.
- `ts_cnt` preset near wrap (TS_WIDTH=8, rise at 255, pulse of 5) → timestamp=255, ToT=5; the next event's timestamp reflects the wrapped count.
- 2-cycle pulse: with `TDC_GLITCH_FILTER_EN` and `MIN_TOT`=3 → no event, `lost_events`=0; without the macro → event with ToT=2.
- `reset` asserted in HIGH and again in READY → all outputs 0 the next cycle; a pulse after reset captures normally.

Source files
------------

// File: rtl/tdc_channel_if.sv
// Event bus between one TDC channel (master) and the output controller (slave).
interface tdc_channel_if #(
  parameter int CHAN_WIDTH = 4,
  parameter int TOT_WIDTH  = 16,
  parameter int TS_WIDTH   = 48
);
  logic                  sig_in;
  logic                  enable;
  logic                  clear;
  logic                  has_event;
  logic [CHAN_WIDTH-1:0] chan;
  logic [TOT_WIDTH-1:0]  time_over_threshold;
  logic [TS_WIDTH-1:0]   timestamp;
  logic [15:0]           lost_events;

  modport master (
    input  sig_in, enable, clear,
    output has_event, chan, time_over_threshold, timestamp, lost_events
  );

  modport slave (
    output sig_in, enable, clear,
    input  has_event, chan, time_over_threshold, timestamp, lost_events
  );
endinterface

// File: rtl/tdc_channel.sv
// Single-channel TDC: timestamps synchronized rising edges and measures time-over-threshold.
// Optional feature: define TDC_GLITCH_FILTER_EN to drop pulses shorter than MIN_TOT.
module tdc_channel #(
  parameter int CHANNEL_ID = 0,
  parameter int CHAN_WIDTH = 4,
  parameter int TOT_WIDTH  = 16,
  parameter int TS_WIDTH   = 48,
  parameter int MIN_TOT    = 3
) (
  input logic           clk,
  input logic           reset,
  tdc_channel_if.master bus
);

`ifdef TDC_GLITCH_FILTER_EN
  localparam bit GLITCH_EN = 1'b1;
`else
  localparam bit GLITCH_EN = 1'b0;
`endif

  localparam logic [TOT_WIDTH-1:0] TOT_MAX = '1;
  localparam logic [TOT_WIDTH-1:0] TOT_ONE = TOT_WIDTH'(1);
  localparam logic [TOT_WIDTH-1:0] TOT_MIN = TOT_WIDTH'(MIN_TOT);

  typedef enum logic [1:0] {IDLE, HIGH, READY, WAIT_LOW} state_t;

  state_t                state;
  logic                  sync1;
  logic                  sync2;
  logic                  level;
  logic                  rise;
  logic                  fall;
  logic                  stuck;
  logic [TS_WIDTH-1:0]   ts_cnt;
  logic [TS_WIDTH-1:0]   ts;
  logic [TOT_WIDTH-1:0]  tot;
  logic                  has_event;
  logic [15:0]           lost;

  assign bus.chan                = CHAN_WIDTH'(CHANNEL_ID);
  assign bus.has_event           = has_event;
  assign bus.time_over_threshold = tot;
  assign bus.timestamp           = ts;
  assign bus.lost_events         = lost;

  // level is the same age as rise/fall, so the READY exit sees a consistent signal view
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= bus.sig_in;
      sync2 <= sync1;
      level <= sync2;
      rise  <= sync2 & ~level;
      fall  <= ~sync2 & level;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + TS_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ts        <= '0;
      tot       <= '0;
      has_event <= 1'b0;
      lost      <= '0;
      stuck     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise && bus.enable) begin
            ts    <= ts_cnt;
            tot   <= TOT_ONE;
            state <= HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            if (GLITCH_EN && (tot < TOT_MIN)) begin
              state <= IDLE;
            end else begin
              state     <= READY;
              has_event <= 1'b1;
            end
          end else if (tot == TOT_MAX - TOT_ONE) begin
            // signal never fell: freeze at full scale and flag the channel
            tot       <= TOT_MAX;
            state     <= READY;
            has_event <= 1'b1;
            stuck     <= 1'b1;
          end else begin
            tot <= tot + TOT_ONE;
          end
        end
        READY: begin
          if (bus.clear) begin
            has_event <= 1'b0;
            stuck     <= 1'b0;
            if (rise && bus.enable) begin
              ts    <= ts_cnt;
              tot   <= TOT_ONE;
              state <= HIGH;
            end else if (stuck || !level) begin
              state <= IDLE;
            end else begin
              state <= WAIT_LOW;
            end
          end else if (rise && (lost != 16'hFFFF)) begin
            lost <= lost + 16'd1;
          end
        end
        WAIT_LOW: begin
          if (fall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_channel.sv
// Self-checking bench for tdc_channel: directed scenarios plus randomized pulses
// compared every cycle against an edge-count based event model.
module tb_tdc_channel;

  localparam int CHANNEL_ID = 5;
  localparam int TOT_WIDTH  = 4;
  localparam int TS_WIDTH   = 8;
  localparam int MIN_TOT    = 3;
  localparam int TOT_MAX    = (1 << TOT_WIDTH) - 1;
  localparam int TS_MOD     = 1 << TS_WIDTH;

`ifdef TDC_GLITCH_FILTER_EN
  localparam bit GLITCH_EN = 1'b1;
`else
  localparam bit GLITCH_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  tdc_channel_if #(.CHAN_WIDTH(4), .TOT_WIDTH(TOT_WIDTH), .TS_WIDTH(TS_WIDTH)) bus ();

  tdc_channel #(
    .CHANNEL_ID(CHANNEL_ID),
    .CHAN_WIDTH(4),
    .TOT_WIDTH(TOT_WIDTH),
    .TS_WIDTH(TS_WIDTH),
    .MIN_TOT(MIN_TOT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: the channel sees sig_in delayed by three edges; events are
  // derived from edge numbers of the detected rise/fall and the reset edge.
  bit [3:0] hist;
  bit       model_valid = 1'b0;
  bit       capturing, holding, waiting, stuck_m, zeroed;
  bit       m_rise, m_fall, m_level;
  int       edge_n = 0;
  int       reset_edge = 0;
  int       cap_edge = 0;
  int       exp_ts = 0;
  int       exp_tot = 0;
  int       exp_lost = 0;

  task automatic startCapture();
    capturing = 1'b1;
    cap_edge  = edge_n;
    exp_ts    = (edge_n - reset_edge - 1) % TS_MOD;
    zeroed    = 1'b0;
  endtask

  always @(posedge clk) begin
    edge_n++;
    if (reset) begin
      hist = '0;
      {capturing, holding, waiting, stuck_m} = '0;
      zeroed      = 1'b1;
      exp_ts      = 0;
      exp_tot     = 0;
      exp_lost    = 0;
      reset_edge  = edge_n;
      model_valid = 1'b1;
    end else begin
      m_level = hist[2];
      m_rise  = hist[2] & ~hist[3];
      m_fall  = ~hist[2] & hist[3];
      if (capturing) begin
        if (m_fall) begin
          capturing = 1'b0;
          if (!(GLITCH_EN && (edge_n - cap_edge) < MIN_TOT)) begin
            holding = 1'b1;
            exp_tot = edge_n - cap_edge;
          end
        end else if (edge_n - cap_edge + 1 >= TOT_MAX) begin
          capturing = 1'b0;
          holding   = 1'b1;
          stuck_m   = 1'b1;
          exp_tot   = TOT_MAX;
        end
      end else if (holding) begin
        if (bus.clear) begin
          holding = 1'b0;
          if (m_rise && bus.enable) startCapture();
          else if (!stuck_m && m_level) waiting = 1'b1;
          stuck_m = 1'b0;
        end else if (m_rise && exp_lost < 65535) begin
          exp_lost++;
        end
      end else if (waiting) begin
        if (m_fall) waiting = 1'b0;
      end else if (m_rise && bus.enable) begin
        startCapture();
      end
      hist = {hist[2:0], bus.sig_in};
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("has_event", bus.has_event, holding);
      checkOutput("lost_events", bus.lost_events, exp_lost);
      checkOutput("chan", bus.chan, CHANNEL_ID);
      if (holding || zeroed) begin
        checkOutput("timestamp", bus.timestamp, exp_ts);
        checkOutput("time_over_threshold", bus.time_over_threshold, exp_tot);
      end
    end
  end

  task automatic applyStimulus(input bit s, input bit en, input bit clr, input bit rst);
    @(posedge clk);
    #1;
    bus.sig_in = s;
    bus.enable = en;
    bus.clear  = clr;
    reset      = rst;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pulse(input int n);
    repeat (n) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic clearEvent();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    idle(1);
  endtask

  task automatic checkEvent(input string tag, input int has, input int tot, input int lost);
    @(negedge clk);
    checkOutput({tag, ".has_event"}, bus.has_event, has);
    if (has != 0) checkOutput({tag, ".tot"}, bus.time_over_threshold, tot);
    checkOutput({tag, ".lost"}, bus.lost_events, lost);
  endtask

  initial begin
    bit cur_sig;
    int run_left;
    bus.sig_in = 1'b0;
    bus.enable = 1'b1;
    bus.clear  = 1'b1;

    // basic capture: rise with ts_cnt at 100, 10-cycle pulse
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    idle(97);
    pulse(10);
    idle(6);
    checkEvent("basic", 1, 10, 0);
    checkOutput("basic.timestamp", bus.timestamp, 100);
    checkOutput("basic.chan", bus.chan, CHANNEL_ID);
    clearEvent();
    checkEvent("basic_clear", 0, 0, 0);

    // second pulse while held is lost; clear coinciding with rise captures
    pulse(4);
    idle(6);
    checkEvent("held", 1, 4, 0);
    pulse(4);
    idle(6);
    checkEvent("dropped", 1, 4, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    pulse(2);
    idle(6);
    checkEvent("clear_rise", 1, 6, 1);
    clearEvent();

    // stuck-high input saturates ToT; no recapture until fall then rise
    pulse(20);
    checkEvent("saturate", 1, TOT_MAX, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    pulse(10);
    checkEvent("stuck_high", 0, 0, 1);
    idle(4);
    pulse(4);
    idle(6);
    checkEvent("after_stuck", 1, 4, 1);
    clearEvent();

    // reset while measuring, then while holding
    pulse(5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    idle(1);
    checkEvent("reset_high", 0, 0, 0);
    checkOutput("reset_high.timestamp", bus.timestamp, 0);
    checkOutput("reset_high.tot", bus.time_over_threshold, 0);
    pulse(4);
    idle(6);
    checkEvent("pre_reset", 1, 4, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    idle(1);
    checkEvent("reset_ready", 0, 0, 0);
    checkOutput("reset_ready.timestamp", bus.timestamp, 0);

    // short pulse: filtered or reported depending on build
    pulse(2);
    idle(6);
    if (GLITCH_EN) checkEvent("glitch", 0, 0, 0);
    else           checkEvent("glitch", 1, 2, 0);
    clearEvent();
    pulse(7);
    idle(6);
    checkEvent("post_reset", 1, 7, 0);
    clearEvent();

    // timestamp wrap: rise at ts_cnt 255, next event lands at 16
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    idle(252);
    pulse(5);
    idle(6);
    checkEvent("wrap", 1, 5, 0);
    checkOutput("wrap.timestamp", bus.timestamp, 255);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    idle(5);
    pulse(3);
    idle(6);
    checkEvent("wrapped", 1, 3, 0);
    checkOutput("wrapped.timestamp", bus.timestamp, 16);
    clearEvent();

    // randomized pulse trains with random clears, enables and rare resets
    cur_sig  = 1'b0;
    run_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run_left == 0) begin
        cur_sig  = ~cur_sig;
        run_left = $urandom_range(1, 20);
      end
      run_left--;
      applyStimulus(cur_sig, $urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 499) == 0);
    end
    idle(10);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
